// File: rtl/serv_rf_serdes_pkg.sv
// Shared state encoding for the serial register-file front end.
package serv_rf_serdes_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StLoad = 3'd2,
        StRun  = 3'd3,
        StWb   = 3'd4
    } state_e;

endpackage

// File: rtl/ser_shreg.sv
// WIDTH-bit shift register: parallel load, serial out at the LSB, serial in at the MSB.
module ser_shreg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sin,
    output logic             o_sout,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load has priority so a word can be captured regardless of the shift enable.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_sout = r_q[0];
    assign o_q    = r_q;

endmodule

// File: rtl/serv_rf_serdes.sv
// Reads rs1/rs2 from a parallel register file, streams them LSB-first to a bit-serial
// ALU, collects the serial result and writes it back to rd.
module serv_rf_serdes
    import serv_rf_serdes_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_wen,
    output logic              o_busy,
    output logic              o_rf_rreq,
    output logic [ADDR_W-1:0] o_rf_raddr0,
    output logic [ADDR_W-1:0] o_rf_raddr1,
    input  logic [WIDTH-1:0]  i_rf_rdata0,
    input  logic [WIDTH-1:0]  i_rf_rdata1,
    output logic              o_rf_wreq,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [WIDTH-1:0]  o_rf_wdata,
    output logic              o_en,
    output logic              o_init,
    output logic              o_cnt_done,
    output logic              o_rs1,
    output logic              o_rs2,
    input  logic              i_rd
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rs1_addr;
    logic [ADDR_W-1:0] r_rs2_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_wen;

    logic              w_load;
    logic              w_run;
    logic              w_last;
    logic [WIDTH-1:0]  w_rs1_ld;
    logic [WIDTH-1:0]  w_rs2_ld;
    logic              w_rs1_sout;
    logic              w_rs2_sout;
    logic              w_rd_sout;
    logic [WIDTH-1:0]  w_rs1_q;
    logic [WIDTH-1:0]  w_rs2_q;
    logic [WIDTH-1:0]  w_rd_q;
    logic              w_unused;

    assign w_load = (r_state == StLoad);
    assign w_run  = (r_state == StRun);
    assign w_last = w_run && (r_cnt == CNT_LAST);

    // x0 reads as zero regardless of what the register file returns.
    assign w_rs1_ld = (r_rs1_addr == '0) ? '0 : i_rf_rdata0;
    assign w_rs2_ld = (r_rs2_addr == '0) ? '0 : i_rf_rdata1;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_rd_wen   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_go) begin
                        r_rs1_addr <= i_rs1_addr;
                        r_rs2_addr <= i_rs2_addr;
                        r_rd_addr  <= i_rd_addr;
                        r_rd_wen   <= i_rd_wen;
                        r_state    <= StReq;
                    end
                end
                StReq: begin
                    r_state <= StLoad;
                end
                StLoad: begin
                    r_cnt   <= '0;
                    r_state <= StRun;
                end
                StRun: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= (r_rd_wen && (r_rd_addr != '0)) ? StWb : StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWb: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    ser_shreg #(
        .WIDTH(WIDTH)
    ) u_rs1_sr (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_shift(w_run),
        .i_data (w_rs1_ld),
        .i_sin  (1'b0),
        .o_sout (w_rs1_sout),
        .o_q    (w_rs1_q)
    );

    ser_shreg #(
        .WIDTH(WIDTH)
    ) u_rs2_sr (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_shift(w_run),
        .i_data (w_rs2_ld),
        .i_sin  (1'b0),
        .o_sout (w_rs2_sout),
        .o_q    (w_rs2_q)
    );

    // Result enters at the MSB, so after WIDTH shifts the first bit sits at [0].
    ser_shreg #(
        .WIDTH(WIDTH)
    ) u_rd_sr (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (1'b0),
        .i_shift(w_run),
        .i_data ({WIDTH{1'b0}}),
        .i_sin  (i_rd),
        .o_sout (w_rd_sout),
        .o_q    (w_rd_q)
    );

    assign w_unused = ^{w_rs1_q, w_rs2_q, w_rd_sout};

    assign o_busy      = (r_state != StIdle);
    assign o_rf_rreq   = (r_state == StReq);
    assign o_rf_raddr0 = r_rs1_addr;
    assign o_rf_raddr1 = r_rs2_addr;
    assign o_rf_wreq   = (r_state == StWb);
    assign o_rf_waddr  = r_rd_addr;
    assign o_rf_wdata  = w_rd_q;
    assign o_en        = w_run;
    assign o_init      = w_run && (r_cnt == '0);
    assign o_cnt_done  = w_last;
    assign o_rs1       = w_run & w_rs1_sout;
    assign o_rs2       = w_run & w_rs2_sout;

endmodule

// File: tb/tb_serv_rf_serdes.sv
// Directed bench for serv_rf_serdes: timing, bit order, x0 handling, back-to-back and reset.
module tb_serv_rf_serdes;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_go;
    logic [ADDR_W-1:0] i_rs1_addr;
    logic [ADDR_W-1:0] i_rs2_addr;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_wen;
    logic              o_busy;
    logic              o_rf_rreq;
    logic [ADDR_W-1:0] o_rf_raddr0;
    logic [ADDR_W-1:0] o_rf_raddr1;
    logic [WIDTH-1:0]  i_rf_rdata0;
    logic [WIDTH-1:0]  i_rf_rdata1;
    logic              o_rf_wreq;
    logic [ADDR_W-1:0] o_rf_waddr;
    logic [WIDTH-1:0]  o_rf_wdata;
    logic              o_en;
    logic              o_init;
    logic              o_cnt_done;
    logic              o_rs1;
    logic              o_rs2;
    logic              i_rd;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    logic [WIDTH-1:0] mem [32];

    always #5 clk = ~clk;

    serv_rf_serdes #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_go       (i_go),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .i_rd_addr  (i_rd_addr),
        .i_rd_wen   (i_rd_wen),
        .o_busy     (o_busy),
        .o_rf_rreq  (o_rf_rreq),
        .o_rf_raddr0(o_rf_raddr0),
        .o_rf_raddr1(o_rf_raddr1),
        .i_rf_rdata0(i_rf_rdata0),
        .i_rf_rdata1(i_rf_rdata1),
        .o_rf_wreq  (o_rf_wreq),
        .o_rf_waddr (o_rf_waddr),
        .o_rf_wdata (o_rf_wdata),
        .o_en       (o_en),
        .o_init     (o_init),
        .o_cnt_done (o_cnt_done),
        .o_rs1      (o_rs1),
        .o_rs2      (o_rs2),
        .i_rd       (i_rd)
    );

    // Register file model: data valid one cycle after the read strobe, noise otherwise.
    always @(posedge clk) begin
        if (o_rf_rreq) begin
            i_rf_rdata0 <= mem[o_rf_raddr0];
            i_rf_rdata1 <= mem[o_rf_raddr1];
        end else begin
            i_rf_rdata0 <= $urandom();
            i_rf_rdata1 <= $urandom();
        end
        if (o_rf_wreq) wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents i_go for one cycle; returns in cycle 1 (REQ).
    task automatic start(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen);
        i_rs1_addr = rs1;
        i_rs2_addr = rs2;
        i_rd_addr  = rd;
        i_rd_wen   = wen;
        i_go       = 1'b1;
        tick();
        i_go       = 1'b0;
    endtask

    // From cycle 1 through RUN; returns in cycle WIDTH+3. loopback=1 drives i_rd=o_rs1,
    // otherwise i_rd = pat[k].
    task automatic run(input logic [31:0] exp1, input logic [31:0] exp2,
                       input logic loopback, input logic [31:0] pat);
        chk("rreq_c1", {31'd0, o_rf_rreq}, 32'd1);
        chk("raddr0", {27'd0, o_rf_raddr0}, {27'd0, i_rs1_addr});
        chk("raddr1", {27'd0, o_rf_raddr1}, {27'd0, i_rs2_addr});
        tick();
        chk("rreq_c2", {31'd0, o_rf_rreq}, 32'd0);
        chk("en_c2", {31'd0, o_en}, 32'd0);
        tick();
        for (int k = 0; k < WIDTH; k++) begin
            chk("en", {31'd0, o_en}, 32'd1);
            chk("busy", {31'd0, o_busy}, 32'd1);
            chk("init", {31'd0, o_init}, {31'd0, k == 0});
            chk("cnt_done", {31'd0, o_cnt_done}, {31'd0, k == WIDTH - 1});
            chk("rs1", {31'd0, o_rs1}, {31'd0, exp1[k]});
            chk("rs2", {31'd0, o_rs2}, {31'd0, exp2[k]});
            i_rd = loopback ? o_rs1 : pat[k];
            tick();
        end
        i_rd = 1'b0;
        chk("en_end", {31'd0, o_en}, 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'h1234_5678;
        mem[5] = 32'h0000_000F;
        mem[6] = 32'h8000_0001;
        i_rst = 1'b1; i_go = 1'b0; i_rd = 1'b0; i_rd_wen = 1'b0;
        i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0;
        tick();
        tick();
        // Reset state
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_outs", {26'd0, o_rf_rreq, o_rf_wreq, o_en, o_init, o_cnt_done, o_rs1},
            32'd0);
        chk("rst_rs2", {31'd0, o_rs2}, 32'd0);
        chk("rst_waddr", {27'd0, o_rf_waddr}, 32'd0);
        chk("rst_wdata", o_rf_wdata, 32'd0);
        chk("rst_raddr", {22'd0, o_rf_raddr0, o_rf_raddr1}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Tests 1 and 6: operand streaming, no writeback
        w0 = wr_cnt;
        start(5'd5, 5'd6, 5'd3, 1'b0);
        run(32'h0000_000F, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF);
        chk("t6_busy_fall", {31'd0, o_busy}, 32'd0);
        chk("t6_no_wreq", {31'd0, o_rf_wreq}, 32'd0);

        // Test 3, started in cycle WIDTH+3 of the previous transaction
        start(5'd0, 5'd6, 5'd0, 1'b1);
        run(32'h0, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF);
        chk("t3_busy", {31'd0, o_busy}, 32'd0);
        chk("t3_no_wreq", {31'd0, o_rf_wreq}, 32'd0);
        tick();
        chk("t13_wr_cnt", wr_cnt - w0, 32'd0);

        // Test 2: loopback writeback
        w0 = wr_cnt;
        start(5'd1, 5'd2, 5'd7, 1'b1);
        run(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h0);
        chk("t2_wreq", {31'd0, o_rf_wreq}, 32'd1);
        chk("t2_busy_wb", {31'd0, o_busy}, 32'd1);
        chk("t2_waddr", {27'd0, o_rf_waddr}, 32'd7);
        chk("t2_wdata", o_rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_wreq_off", {31'd0, o_rf_wreq}, 32'd0);
        chk("t2_idle", {31'd0, o_busy}, 32'd0);
        chk("t2_wr_cnt", wr_cnt - w0, 32'd1);

        // Bit order: i_rd captured in RUN cycle k lands in wdata[k]
        start(5'd2, 5'd5, 5'd9, 1'b1);
        run(32'h1234_5678, 32'h0000_000F, 1'b0, 32'h0F0F_3C5A);
        chk("order_wreq", {31'd0, o_rf_wreq}, 32'd1);
        chk("order_waddr", {27'd0, o_rf_waddr}, 32'd9);
        chk("order_wdata", o_rf_wdata, 32'h0F0F_3C5A);
        tick();

        // Test 4: i_go held high; accepted at cycles 0 and WIDTH+4 only
        w0 = wr_cnt;
        i_rs1_addr = 5'd5; i_rs2_addr = 5'd6; i_rd_addr = 5'd8; i_rd_wen = 1'b1;
        i_go = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            chk("t4_rreq", {31'd0, o_rf_rreq}, {31'd0, (c == 1) || (c == 37)});
            chk("t4_wreq", {31'd0, o_rf_wreq}, {31'd0, (c == 35) || (c == 71)});
            if (c == 71) i_go = 1'b0;
        end
        chk("t4_idle", {31'd0, o_busy}, 32'd0);
        chk("t4_wr_cnt", wr_cnt - w0, 32'd2);

        // Test 5: reset in RUN cycle 10 discards the pending write
        w0 = wr_cnt;
        start(5'd5, 5'd6, 5'd4, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 10; k++) tick();
        chk("t5_en_pre", {31'd0, o_en}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t5_busy", {31'd0, o_busy}, 32'd0);
        chk("t5_en", {31'd0, o_en}, 32'd0);
        for (int k = 0; k < 40; k++) tick();
        chk("t5_still_idle", {31'd0, o_busy}, 32'd0);
        chk("t5_wr_cnt", wr_cnt - w0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
